ro_freq_counter: RTL and testbench
==================================

Name: ro_freq_counter

Overview:
- Measurement end of the on-tile ring oscillator.
- Drives the oscillator's activate input, waits for the oscillator to settle, then counts rising edges of the oscillator output over a programmable window of clk cycles.
- Latches the result and reports it with a one-cycle done pulse.
- Counting is in the clk domain through a 2-flop synchronizer. Valid only for RO frequency < clk/2; faster oscillators go through an external divider first.

Parameters:
- CNT_W, 16, width of edge count result.
- WIN_W, 16, width of window_len (window length in clk cycles).
- SETTLE_CYCLES, 4, clk cycles ro_activate is held high before counting starts (minimum 2; covers oscillator enable register plus synchronizer).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request a measurement; sampled only in IDLE.
- abort  input  1  cancel a measurement in progress.
- window_len  input  WIN_W  measurement window in clk cycles; latched on accepted start.
- ro_in  input  1  oscillator output, asynchronous to clk.
- ro_activate  output  1  enable to the ring oscillator, registered.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when count is updated.
- count  output  CNT_W  last completed edge count; holds until the next completion.
- ovf  output  1  last completed measurement saturated.

Behaviour:
- Reset (rst_n low, async): state IDLE; ro_activate=0, busy=0, done=0, count=0, ovf=0; synchronizer and edge-history flops=0; window and settle counters=0.
- States: IDLE, WARMUP, MEASURE, DONE.
- IDLE:
  - On start=1 at posedge: latch window_len, clear internal edge counter and saturation flag, go to WARMUP.
  - ro_activate and busy rise in the first cycle after the start edge.
- WARMUP:
  - ro_activate=1 for exactly SETTLE_CYCLES cycles, then MEASURE.
  - Edges seen in WARMUP are discarded.
  - If the latched window_len==0: go from WARMUP to DONE with count 0.
- MEASURE:
  - Lasts exactly the latched window_len cycles.
  - Each cycle in which the synchronized ro_in shows 0->1 (sync2=1, prev=0) increments the internal counter.
  - The counter saturates at 2^CNT_W-1 and sets the internal saturation flag; it never wraps.
- DONE (one cycle):
  - count<=internal counter, ovf<=saturation flag, done=1, ro_activate=0.
  - Next state is IDLE; busy=0 from the following cycle.
- Latency: from the start posedge to done = 1 + SETTLE_CYCLES + window_len cycles. Example: SETTLE=4, window=100 gives done in the 105th cycle after the start edge.
- abort=1 in WARMUP or MEASURE:
  - Next cycle: IDLE, ro_activate=0, busy=0.
  - No done pulse; count/ovf unchanged.
  - Abort in IDLE or DONE has no effect; DONE completes normally.
- Simultaneous start and abort in IDLE: abort wins; stay in IDLE.
- start while busy: ignored, not queued.
- Reset mid-measurement: immediate return to the reset values above; previous count is lost.
- window_len changes after acceptance do not affect the running measurement.

Optional Feature:
- Macro: RO_CONT_MODE_EN.
- Defined:
  - Adds input port cont (1 bit).
  - If cont=1 during DONE, the next state is MEASURE instead of IDLE, with the internal counter and saturation flag cleared and window_len re-latched.
  - ro_activate stays 1 through DONE and busy stays 1 (no re-warmup), so done pulses every window_len+1 cycles.
  - abort exits continuous mode as above.
- Not defined:
  - No cont port.
  - DONE always returns to IDLE with ro_activate=0.

Test Plan:
- Basic: clk 10 ns; ro_in period 40 ns; window_len=100, start pulse -> busy for 105 cycles; ro_activate high cycles 1-104; done in cycle 105; count in {24,25}; ovf=0.
- Saturation: CNT_W=4; ro_in period 40 ns; window_len=100 -> count=15, ovf=1; a following run with window_len=20 -> ovf=0, count in {4,5}.
- Abort: start with window_len=1000; abort in MEASURE cycle 50 -> next cycle busy=0, ro_activate=0; no done pulse; count keeps its prior value.
- Zero window and ignore-while-busy: window_len=0 -> done 5 cycles after start with count=0; a second start pulsed during WARMUP of a window_len=10 run -> exactly one done pulse.
- Async reset: assert rst_n low mid-MEASURE, asynchronous to clk -> all outputs 0 before the next clk edge.
- RO_CONT_MODE_EN: cont=1, window_len=50, ro_in period 40 ns -> done every 51 cycles, ro_activate held 1 across them, count in {12,13} each; drop cont -> IDLE after the next done.

Source files
------------

// File: rtl/ro_freq_counter.sv
// rtl/ro_freq_counter.sv - ring oscillator frequency counter with warmup and programmable window
// Optional continuous re-measure mode enabled by RO_CONT_MODE_EN (adds the cont input).
module ro_freq_counter #(
    parameter int CNT_W         = 16,
    parameter int WIN_W         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] window_len,
    input  logic             ro_in,
`ifdef RO_CONT_MODE_EN
    input  logic             cont,
`endif
    output logic             ro_activate,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, MEASURE, DONE} state_t;

    state_t           state;
    logic             sync1, sync2, prev;
    logic [WIN_W-1:0] win_len;
    logic [WIN_W-1:0] win_cnt;
    logic [ST_W-1:0]  settle_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             sat;
    logic             cont_i;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_nxt;

`ifdef RO_CONT_MODE_EN
    assign cont_i = cont;
`else
    assign cont_i = 1'b0;
`endif

    // prev trails sync2 so a 0->1 of the synchronized oscillator is seen exactly once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_comb begin
        cnt_nxt = edge_cnt;
        sat_nxt = sat;
        if (state == MEASURE && sync2 && !prev) begin
            if (&edge_cnt) sat_nxt = 1'b1;
            else           cnt_nxt = edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ro_activate <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            count       <= '0;
            ovf         <= 1'b0;
            win_len     <= '0;
            win_cnt     <= '0;
            settle_cnt  <= '0;
            edge_cnt    <= '0;
            sat         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        win_len     <= window_len;
                        edge_cnt    <= '0;
                        sat         <= 1'b0;
                        settle_cnt  <= '0;
                        state       <= WARMUP;
                        ro_activate <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                WARMUP: begin
                    if (abort) begin
                        state       <= IDLE;
                        ro_activate <= 1'b0;
                        busy        <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        if (win_len == '0) begin
                            state       <= DONE;
                            count       <= '0;
                            ovf         <= 1'b0;
                            done        <= 1'b1;
                            ro_activate <= cont_i;
                        end else begin
                            state   <= MEASURE;
                            win_cnt <= '0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    edge_cnt <= cnt_nxt;
                    sat      <= sat_nxt;
                    if (abort) begin
                        state       <= IDLE;
                        ro_activate <= 1'b0;
                        busy        <= 1'b0;
                    end else if (win_cnt == win_len - 1'b1) begin
                        state       <= DONE;
                        count       <= cnt_nxt;
                        ovf         <= sat_nxt;
                        done        <= 1'b1;
                        ro_activate <= cont_i;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (cont_i) begin
                        // continuous mode re-arms straight into a fresh window, no warmup
                        win_len  <= window_len;
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                        if (window_len == '0) begin
                            count       <= '0;
                            ovf         <= 1'b0;
                            done        <= 1'b1;
                            ro_activate <= 1'b1;
                        end else begin
                            state       <= MEASURE;
                            ro_activate <= 1'b1;
                        end
                    end else begin
                        state       <= IDLE;
                        ro_activate <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    ro_activate <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb/tb_ro_freq_counter.sv - randomized self-checking bench for ro_freq_counter
module tb_ro_freq_counter;
    localparam int CNT_W = 6;
    localparam int WIN_W = 12;
    localparam int S     = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIN_W-1:0] window_len = '0;
    logic             ro_in = 1'b0;
    logic             ro_activate, busy, done, ovf;
    logic [CNT_W-1:0] count;
    logic             cont_s;
`ifdef RO_CONT_MODE_EN
    logic             cont = 1'b0;
    assign cont_s = cont;
`else
    assign cont_s = 1'b0;
`endif

    ro_freq_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .window_len(window_len), .ro_in(ro_in),
`ifdef RO_CONT_MODE_EN
        .cont(cont),
`endif
        .ro_activate(ro_activate), .busy(busy), .done(done), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // oscillator toggles stay at 2 mod 5 time units, never on a clock edge
    int ro_half = 20;
    bit ro_rand = 1'b0;
    initial begin
        #2;
        forever begin
            if (ro_rand) #(5 * $urandom_range(3, 8));
            else         #(ro_half);
            ro_in = ~ro_in;
        end
    end

    int n_chk = 0, n_fail = 0;
    int cyc = 0, done_total = 0, busy_cnt = 0, act_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_in(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d..%0d", nm, cyc, act, lo, hi);
        end
    endtask

    // reference model: a measurement is an interval of edge indices; counts come from sampled history
    bit samp[int];
    bit m_active = 0, m_busy = 0, m_act = 0, m_done = 0, m_ovf = 0;
    int m_count = 0, m_meas = 0, m_done_edge = 0;

    always @(negedge rst_n) begin
        m_active = 0; m_busy = 0; m_act = 0; m_done = 0; m_count = 0; m_ovf = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            int n;
            cyc++;
            samp[cyc] = ro_in;
            m_done = 0;
            if (m_active) begin
                if (cyc == m_done_edge + 1) begin
                    if (cont_s) begin
                        m_meas = cyc;
                        m_done_edge = cyc + int'(window_len);
                    end else begin
                        m_active = 0;
                    end
                end else if (abort) begin
                    m_active = 0;
                end
            end else if (start && !abort) begin
                m_active = 1;
                m_meas = cyc + S;
                m_done_edge = cyc + S + int'(window_len);
            end
            if (m_active && cyc == m_done_edge) begin
                n = 0;
                for (int e = m_meas; e < m_done_edge; e++)
                    if (samp[e-1] && !samp[e-2]) n++;
                m_count = (n > MAXC) ? MAXC : n;
                m_ovf = (n > MAXC);
                m_done = 1;
            end
            m_busy = m_active;
            m_act = m_active && (cyc < m_done_edge || (cyc == m_done_edge && cont_s));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, m_busy);
            chk("ro_activate", ro_activate, m_act);
            chk("done", done, m_done);
            chk("count", count, m_count);
            chk("ovf", ovf, m_ovf);
            if (done) done_total++;
            if (busy) busy_cnt++;
            if (ro_activate) act_cnt++;
        end
    end

    task automatic pulse_start(input int w, output int e0);
        busy_cnt = 0;
        act_cnt = 0;
        window_len = WIN_W'(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input int bound, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout at cycle %0d: got no done expected done within %0d", cyc, bound);
        end
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && busy; k++) @(negedge clk);
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        int e0, at, prev, d0, w;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_act", ro_activate, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pulse_start(100, e0);
        wait_done(200, at);
        chk("basic_latency", at - e0 + 1, 105);
        chk_in("basic_count", count, 24, 25);
        chk_in("basic_model", m_count, 24, 25);
        chk("basic_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        chk("basic_busy_cycles", busy_cnt, 105);
        chk("basic_act_cycles", act_cnt, 104);

        pulse_start(300, e0);
        wait_done(400, at);
        chk("sat_count", count, MAXC);
        chk("sat_ovf", ovf, 1);
        repeat (2) @(negedge clk);
        pulse_start(20, e0);
        wait_done(100, at);
        chk_in("post_sat_count", count, 4, 5);
        chk("post_sat_ovf", ovf, 0);
        repeat (2) @(negedge clk);

        pulse_start(1000, e0);
        repeat (S + 49) @(negedge clk);
        d0 = done_total;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_act", ro_activate, 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_total - d0, 0);
        chk_in("abort_count_kept", count, 4, 5);

        window_len = 10;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);

        pulse_start(0, e0);
        wait_done(20, at);
        chk("zero_latency", at - e0 + 1, 5);
        chk("zero_count", count, 0);
        repeat (2) @(negedge clk);

        d0 = done_total;
        pulse_start(10, e0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("ignore_one_done", done_total - d0, 1);

`ifdef RO_CONT_MODE_EN
        cont = 1'b1;
        pulse_start(50, e0);
        wait_done(100, at);
        chk_in("cont_count", count, 12, 13);
        prev = at;
        for (int i = 0; i < 3; i++) begin
            wait_done(60, at);
            chk("cont_period", at - prev, 51);
            chk_in("cont_count", count, 12, 13);
            chk("cont_act_held", ro_activate, 1);
            prev = at;
        end
        @(negedge clk);
        cont = 1'b0;
        wait_done(60, at);
        chk("cont_last_period", at - prev, 51);
        @(negedge clk);
        chk("cont_exit_idle", busy, 0);
`endif

        ro_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            w = $urandom_range(0, 300);
            window_len = WIN_W'(w);
            start = 1'b1;
            abort = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            for (int k = 0; k < w + S + 10; k++) begin
                @(negedge clk);
                start = ($urandom_range(0, 15) == 0);
                abort = ($urandom_range(0, 299) == 0);
                window_len = WIN_W'($urandom_range(0, 300));
            end
            start = 1'b0;
            abort = 1'b0;
            wait_idle(1000);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        ro_rand = 1'b0;

        pulse_start(200, e0);
        repeat (60) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_act", ro_activate, 0);
        chk("arst_done", done, 0);
        chk("arst_count", count, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
